// File: rtl/clb_serial_add_ctrl.sv
// clb_serial_add_ctrl: sequences a WIDTH-bit add through one 2-bit registered CLB adder,
// one digit per cycle LSB first, chaining the CLB carry and assembling the result.
module clb_serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             clb_reset,
    output logic             clb_c_in,
    output logic [1:0]       clb_input_1,
    output logic [1:0]       clb_input_2,
    input  logic [1:0]       clb_sum,
    input  logic             clb_c_out
);
    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state, state_nx;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q, b_q;
    logic             cin_q;
    logic [1:0]       dig_a, dig_b;
    logic             last;

    assign last        = idx == IW'(N - 1);
    assign busy        = state != IDLE;
    assign clb_reset   = ~reset;
    assign clb_input_1 = state == RUN ? dig_a : 2'b00;
    assign clb_input_2 = state == RUN ? dig_b : 2'b00;
    // Digit 0 takes the requester's carry; later digits chain the CLB's registered carry.
    assign clb_c_in    = state == RUN ? (idx == '0 ? cin_q : clb_c_out) : 1'b0;

    always_comb begin
        dig_a = 2'b00;
        dig_b = 2'b00;
        for (int d = 0; d < N; d++)
            if (idx == IW'(d)) begin
                dig_a = a_q[2*d +: 2];
                dig_b = b_q[2*d +: 2];
            end
    end

    always_comb begin
        state_nx = state == IDLE ? (start ? RUN : IDLE) :
                   state == RUN  ? (last ? DRAIN : RUN) : IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            c_out  <= 1'b0;
        end else begin
            done <= state == DRAIN;
            if (state == IDLE && start) begin
                a_q   <= op_a;
                b_q   <= op_b;
                cin_q <= c_in;
                idx   <= '0;
            end
            // The CLB sum seen during digit i belongs to digit i-1.
            if (state == RUN) begin
                if (!last) idx <= idx + IW'(1);
                for (int d = 1; d < N; d++)
                    if (idx == IW'(d)) result[2*d-2 +: 2] <= clb_sum;
            end
            if (state == DRAIN) begin
                result[WIDTH-1 -: 2] <= clb_sum;
                c_out                <= clb_c_out;
            end
        end
    end
endmodule

// File: tb/tb_clb_serial_add_ctrl.sv
// tb_clb_serial_add_ctrl: directed vectors and corner sequences for the serial add sequencer,
// driving a behavioural 2-bit registered CLB adder.
module tb_clb_serial_add_ctrl;
    localparam int W = 8;
    localparam int N = W / 2;

    logic         clock = 1'b0, reset = 1'b0, start = 1'b0, c_in = 1'b0;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic         busy, done, c_out, clb_reset, clb_c_in, clb_c_out;
    logic [W-1:0] result;
    logic [1:0]   clb_input_1, clb_input_2, clb_sum;

    int total = 0, bad = 0;

    clb_serial_add_ctrl #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b), .c_in(c_in),
        .busy(busy), .done(done), .result(result), .c_out(c_out), .clb_reset(clb_reset),
        .clb_c_in(clb_c_in), .clb_input_1(clb_input_1), .clb_input_2(clb_input_2),
        .clb_sum(clb_sum), .clb_c_out(clb_c_out)
    );

    always #5 clock = ~clock;

    always_ff @(posedge clock or posedge clb_reset) begin
        if (clb_reset) {clb_c_out, clb_sum} <= 3'b000;
        else {clb_c_out, clb_sum} <= {1'b0, clb_input_1} + {1'b0, clb_input_2} + {2'b00, clb_c_in};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          output logic [W-1:0] r, output logic co, output int lat);
        @(negedge clock);
        start = 1'b1; op_a = a; op_b = b; c_in = ci;
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        r = result;
        co = c_out;
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic         ci;
        logic [W-1:0] res;
        logic         co;
    } vec_t;

    initial begin
        vec_t         vt[8];
        logic [W-1:0] r;
        logic         co;
        int           lat, busy_n, done_n;
        logic [3:0]   dig_exp[4];

        vt[0] = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vt[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vt[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vt[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vt[6] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
        vt[7] = '{8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1};
        dig_exp[0] = 4'b1000; dig_exp[1] = 4'b1011; dig_exp[2] = 4'b0111; dig_exp[3] = 4'b0100;

        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_c_out", c_out, 0);
        check("rst_clb_reset", clb_reset, 1);
        check("rst_clb_in", {clb_c_in, clb_input_1, clb_input_2}, 0);
        #10 reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].ci, r, co, lat);
            check($sformatf("vec%0d_result", i), r, vt[i].res);
            check($sformatf("vec%0d_c_out", i), co, vt[i].co);
            check($sformatf("vec%0d_latency", i), lat, N + 1);
            @(negedge clock);
            check($sformatf("vec%0d_done_width", i), done, 0);
        end

        // Digit issue order and carry chaining
        @(negedge clock);
        start = 1'b1; op_a = 8'h5A; op_b = 8'h3C; c_in = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            check($sformatf("digit%0d", k), {clb_input_1, clb_input_2}, dig_exp[k]);
            @(negedge clock);
        end
        check("drain_inputs_zero", {clb_input_1, clb_input_2}, 0);
        @(negedge clock);
        check("digits_done", done, 1);
        start = 1'b1; op_a = 8'hFF; op_b = 8'h01; c_in = 1'b0;
        @(negedge clock);
        start = 1'b0;
        check("ripple_cin0", clb_c_in, 0);
        for (int k = 1; k < N; k++) begin
            @(negedge clock);
            check($sformatf("ripple_cin%0d", k), clb_c_in, 1);
        end
        repeat (2) @(negedge clock);
        check("ripple_result", {c_out, result}, 9'h100);

        // Back-to-back: start held in the done cycle
        repeat (2) @(negedge clock);
        start = 1'b1; op_a = 8'hA5; op_b = 8'h5A; c_in = 1'b1;
        @(negedge clock);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("b2b_first", {c_out, result}, 9'h100);
        op_a = 8'h00; op_b = 8'h00; c_in = 1'b0;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("b2b_gap", lat, N + 2);
        check("b2b_second", {c_out, result}, 9'h000);

        // Start while busy is ignored
        @(negedge clock);
        start = 1'b1; op_a = 8'h12; op_b = 8'h34; c_in = 1'b0;
        busy_n = 0; done_n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            busy_n += int'(busy);
            done_n += int'(done);
            start = (i == 2 || i == 3);
            if (start) begin op_a = 8'hFF; op_b = 8'hFF; c_in = 1'b1; end
        end
        start = 1'b0;
        check("ignore_busy_cycles", busy_n, 5);
        check("ignore_done_count", done_n, 1);
        check("ignore_result", {c_out, result}, 9'h046);

        // Asynchronous reset in RUN at idx=2
        @(negedge clock);
        start = 1'b1; op_a = 8'h5A; op_b = 8'h3C; c_in = 1'b1;
        repeat (3) @(negedge clock);
        start = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        check("arst_c_out", c_out, 0);
        check("arst_clb_reset", clb_reset, 1);
        #1 reset = 1'b1;
        run_op(8'h01, 8'h01, 1'b0, r, co, lat);
        check("arst_after", {co, r}, 9'h002);

        // Random operations with random idle gaps
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a, b;
            logic         ci;
            a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clock);
            run_op(a, b, ci, r, co, lat);
            check($sformatf("rand%0d_sum", i), {co, r}, {1'b0, a} + {1'b0, b} + {8'h00, ci});
            check($sformatf("rand%0d_latency", i), lat, N + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clb_serial_add_ctrl.md
Name: clb_serial_add_ctrl

Overview:
Sequencer that performs WIDTH-bit addition by time-multiplexing one 2-bit registered LUT adder CLB. It accepts operands over a start/done handshake and feeds the CLB one 2-bit digit per cycle, LSB digit first. It chains the CLB carry output back into the CLB carry input and assembles the result. It sits between a requesting datapath and a single CLB instance.

Parameters:
WIDTH, 8, operand/result width in bits; must be even and >= 2; N = WIDTH/2 digits.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  request; sampled only in IDLE.
op_a  input  WIDTH  operand A.
op_b  input  WIDTH  operand B.
c_in  input  1  carry into digit 0.
busy  output  1  high in RUN and DRAIN.
done  output  1  one-cycle pulse: result/c_out valid.
result  output  WIDTH  sum; held until the next accepted start.
c_out  output  1  final carry; held with result.
clb_reset  output  1  active-high reset to the CLB; equals ~reset, combinational.
clb_c_in  output  1  CLB carry in.
clb_input_1  output  2  CLB operand 1 (digit of op_a).
clb_input_2  output  2  CLB operand 2 (digit of op_b).
clb_sum  input  2  CLB registered sum.
clb_c_out  input  1  CLB registered carry.

Behaviour:
- Reset values: state=IDLE, idx=0, busy=0, done=0, result=0, c_out=0, operand/carry latches=0. clb_reset is high while reset is low.
- CLB contract: inputs presented in cycle k are registered at the end of cycle k. clb_sum and clb_c_out are therefore valid during cycle k+1.
- IDLE:
  - With start=1 at an edge: latch op_a, op_b, c_in; set idx=0; go to RUN.
  - Otherwise stay in IDLE.
  - CLB inputs are driven to 0.
- RUN (idx=i, 0..N-1):
  - Drive clb_input_1 = a[2i+1:2i] and clb_input_2 = b[2i+1:2i].
  - clb_c_in = latched c_in when i=0; otherwise clb_c_out, as a combinational pass-through.
  - At the edge, if i>0, capture clb_sum into result[2i-1:2i-2].
  - If i=N-1, go to DRAIN; otherwise idx=i+1.
- DRAIN:
  - CLB inputs are driven to 0.
  - At the edge, capture clb_sum into result[WIDTH-1:WIDTH-2] and clb_c_out into c_out.
  - Set done=1 and go to IDLE.
- done is registered and high for exactly the first IDLE cycle after DRAIN.
- Latency: if start is accepted at edge E0, done is high in the cycle following edge E(N+1). For WIDTH=8, that is the cycle after E5. Throughput is one add per N+2 cycles.
- result and c_out are updated only by RUN/DRAIN captures. Between operations they hold the last completed value. During an operation, partial result bits are visible; consumers must wait for done.
- start while busy=1 is ignored: no latch, no effect on the operation in flight.
- start during the done cycle is accepted, because the state is IDLE. The new operation begins with no bubble, and done still pulses for the old result.
- WIDTH=2 (N=1): RUN lasts 1 cycle, then DRAIN. The digit-0 carry is always the latched c_in.
- Reset mid-operation: all state returns to IDLE immediately (asynchronous) and the CLB is reset. No done is produced, and result/c_out clear to 0.
- Arithmetic: {c_out, result} = op_a + op_b + c_in, exact modulo 2^(WIDTH+1).

Test Plan:
1. WIDTH=8, op_a=0x5A, op_b=0x3C, c_in=1 -> digits issued (input_1,input_2) = (10,00),(10,11),(01,11),(01,00); done after edge 5; result=0x97, c_out=0.
2. op_a=0xFF, op_b=0x01, c_in=0 -> carry ripples through all 4 digits; result=0x00, c_out=1; clb_c_in=1 for digits 1..3.
3. op_a=0xA5, op_b=0x5A, c_in=1 -> result=0x00, c_out=1. Then op_a=0x00, op_b=0x00, c_in=0 with start held in the done cycle -> accepted back-to-back; second done exactly 6 cycles later; result=0x00, c_out=0.
4. Start 0x12+0x34, then pulse start with 0xFF/0xFF on edges 2 and 3 -> ignored; result=0x46, c_out=0; busy high for exactly 5 cycles.
5. Assert reset low in RUN at idx=2 -> asynchronously busy=0, done=0, result=0, c_out=0, clb_reset=1. After release, 0x01+0x01 gives result=0x02.
6. Random op_a/op_b/c_in, 1000 operations with random start gaps -> {c_out,result} matches the reference sum; exactly one done per accepted start.
